fp_result_buffer: RTL

- Downstream stage of floating_point_multiplier: captures each product word plus its three exception flags through a valid/ready handshake.
- Holds entries in a first-word-fall-through FIFO of DEPTH entries for a consumer that can stall.
- Keeps an IEEE-style sticky status register (OR of all accepted flags) until software clears it.
- Counts accepted results with a saturating counter.

---
 rtl/fp_pkg.sv | 16 +
 rtl/sync_fwft_fifo.sv | 56 +++++
 rtl/fp_result_buffer.sv | 79 +++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: exception flag bit positions, word width helper, flag vector type.
// Combinational definitions only; no latency or backpressure.
package fp_pkg;

  localparam int FLAG_UNDERFLOW = 0;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_INVALID   = 2;
  localparam int NUM_FLAGS      = 3;

  typedef logic [NUM_FLAGS-1:0] fp_flags_t;

  function automatic int float_width(input int exponent_width, input int mantissa_width);
    return exponent_width + mantissa_width + 1;
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Generic synchronous first-word-fall-through FIFO with flush and occupancy output.
// Latency: a word written at edge N is on rd_dat after edge N. Backpressure: wr_rdy drops at full, from registered state only.
module sync_fwft_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_vld,
  output logic                     wr_rdy,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic                     rd_vld,
  input  logic                     rd_rdy,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign wr_rdy = (fill_level != LW'(DEPTH));
  assign rd_vld = (fill_level != '0);
  assign push   = wr_vld && wr_rdy && !flush;
  assign pop    = rd_vld && rd_rdy && !flush;

  // Empty FIFO presents zeros rather than stale storage.
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fill_level <= fill_level + LW'(1);
        2'b01:   fill_level <= fill_level - LW'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/fp_result_buffer.sv
// Buffers multiplier results with flags in a FWFT FIFO, keeps sticky exception status and a saturating result count.
// Latency 1 cycle push-to-head; in_ready drops at full, independent of out_ready.
module fp_result_buffer
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int DEPTH          = 4,
  parameter int COUNT_WIDTH    = 16,
  localparam int W             = float_width(EXPONENT_WIDTH, MANTISSA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_result,
  input  logic [NUM_FLAGS-1:0]     in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_result,
  output logic [NUM_FLAGS-1:0]     out_flags,
  output logic [NUM_FLAGS-1:0]     sticky_flags,
  input  logic                     clear_flags,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [COUNT_WIDTH-1:0]   result_count
);

  typedef struct packed {
    logic [W-1:0] result;
    fp_flags_t    flags;
  } entry_t;

  entry_t wr_entry;
  entry_t rd_entry;
  logic   push;

  assign wr_entry.result = in_result;
  assign wr_entry.flags  = in_flags;
  assign out_result      = rd_entry.result;
  assign out_flags       = rd_entry.flags;

  // Must match the FIFO's own accept condition: a word offered with flush is dropped.
  assign push = in_valid && in_ready && !flush;

  sync_fwft_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .wr_vld     (in_valid),
    .wr_rdy     (in_ready),
    .wr_dat     (wr_entry),
    .rd_vld     (out_valid),
    .rd_rdy     (out_ready),
    .rd_dat     (rd_entry),
    .fill_level (fill_level)
  );

  // Clear and a coinciding flagged push: the new flags survive.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= '0;
    end else begin
      sticky_flags <= (clear_flags ? '0 : sticky_flags) | (push ? in_flags : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_count <= '0;
    end else if (push && (result_count != '1)) begin
      result_count <= result_count + COUNT_WIDTH'(1);
    end
  end

endmodule
